// File: rtl/io_controller_if.sv
// Control-unit side strobes for the I/O and interrupt responder.
// Strobes are single-cycle and sampled at the rising clock edge. There is no ready path.
// io_interrupt is a level that stays up until the CPU stores the return address.
interface io_controller_if;
  logic       io_read;
  logic       io_write;
  logic       io_push;
  logic       io_addr_read;
  logic [3:0] io_addr;
  logic       io_store_retaddr;
  logic       io_push_retaddr;
  logic       io_push_ints;
  logic       io_push_int_addr;
  logic       io_interrupt;

  modport master (
    output io_read, io_write, io_push, io_addr_read, io_addr,
           io_store_retaddr, io_push_retaddr, io_push_ints, io_push_int_addr,
    input  io_interrupt
  );

  modport slave (
    input  io_read, io_write, io_push, io_addr_read, io_addr,
           io_store_retaddr, io_push_retaddr, io_push_ints, io_push_int_addr,
    output io_interrupt
  );
endinterface

// File: rtl/io_controller.sv
// CPU-side I/O responder: device port reads and writes, interrupt capture and
// prioritisation, vector address supply and return-address save and restore.
module io_controller #(
  parameter logic [15:0] VECTOR_BASE = 16'hFFF0,
  parameter logic [3:0]  CTRL_PORT   = 4'hF
) (
  input  logic             clk,
  input  logic             rst,
  io_controller_if.slave   cu,
  inout  wire  [15:0]      d_bus,
  output wire  [15:0]      a_bus,
  input  logic [15:0]      irq_in,
  output logic [3:0]       ext_addr,
  output logic             ext_rd,
  output logic             ext_wr,
  output logic [15:0]      ext_wdata,
  input  logic [15:0]      ext_rdata,
  output logic             bus_conflict,
  output logic [1:0]       dbg_state_o,
  output logic [15:0]      dbg_pending_o,
  output logic             dbg_in_service_o
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_HELD = 2'd1,
    ST_SERVICE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] rd_buf_q, rd_buf_d;
  logic [15:0] retaddr_q, retaddr_d;
  logic [15:0] pending_q, pending_d;
  logic [15:0] irq_en_q, irq_en_d;
  logic [15:0] irq_prev_q;
  logic        in_service_q, in_service_d;
  logic        conflict_q, conflict_d;

  logic        rd_req, wr_req, is_ctrl, store_acc;
  logic [15:0] eligible;
  logic [3:0]  idx;
  logic        has_eligible;
  logic [15:0] clr_mask;
  logic        d_drv_en;
  logic [15:0] d_drv;

  assign is_ctrl   = (cu.io_addr == CTRL_PORT);
  assign rd_req    = cu.io_read  & cu.io_addr_read;
  assign wr_req    = cu.io_write & cu.io_addr_read;
  assign store_acc = cu.io_store_retaddr & (state_q != ST_SERVICE);

  assign ext_addr  = cu.io_addr;
  assign ext_rd    = rd_req & ~is_ctrl;
  assign ext_wr    = wr_req & ~is_ctrl;
  assign ext_wdata = d_bus;

  assign eligible        = pending_q & irq_en_q;
  assign cu.io_interrupt = (|eligible) & ~in_service_q;

  // Lowest-index eligible line wins; the loop runs downward so the last hit is the lowest.
  always_comb begin
    idx          = 4'd0;
    has_eligible = 1'b0;
    for (int i = 15; i >= 0; i--) begin
      if (eligible[i]) begin
        idx          = i[3:0];
        has_eligible = 1'b1;
      end
    end
  end

  always_comb begin
    clr_mask = 16'h0000;
    if (store_acc && has_eligible) clr_mask[idx] = 1'b1;
  end

  always_comb begin
    d_drv_en = 1'b0;
    d_drv    = 16'h0000;
    if (cu.io_push) begin
      d_drv_en = 1'b1;
      d_drv    = rd_buf_q;
    end else if (cu.io_push_retaddr) begin
      d_drv_en = 1'b1;
      d_drv    = retaddr_q;
    end else if (cu.io_push_ints) begin
      d_drv_en = 1'b1;
      d_drv    = pending_q;
    end
  end

  // Both shared buses float for as long as reset is held.
  assign d_bus = (d_drv_en && !rst) ? d_drv : 16'hzzzz;
  assign a_bus = (cu.io_push_int_addr && !rst) ? (VECTOR_BASE + {12'h000, idx}) : 16'hzzzz;

  always_comb begin
    rd_buf_d     = rd_buf_q;
    retaddr_d    = retaddr_q;
    irq_en_d     = irq_en_q;
    in_service_d = in_service_q;
    conflict_d   = (cu.io_push & cu.io_push_retaddr) | (cu.io_push & cu.io_push_ints) |
                   (cu.io_push_retaddr & cu.io_push_ints);
    // A new rising edge beats a same-cycle acknowledge of the same line.
    pending_d    = (pending_q & ~clr_mask) | (irq_in & ~irq_prev_q);

    if (rd_req) rd_buf_d = is_ctrl ? irq_en_q : ext_rdata;
    if (wr_req && is_ctrl) irq_en_d = d_bus;
    if (store_acc) begin
      retaddr_d    = d_bus;
      in_service_d = 1'b1;
    end else if (cu.io_push_retaddr) begin
      in_service_d = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (store_acc)   state_d = ST_SERVICE;
        else if (rd_req) state_d = ST_RD_HELD;
      end
      ST_RD_HELD: begin
        if (store_acc)        state_d = ST_SERVICE;
        else if (rd_req)      state_d = ST_RD_HELD;
        else if (cu.io_push)  state_d = ST_IDLE;
      end
      ST_SERVICE: begin
        if (cu.io_push_retaddr) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      rd_buf_q     <= 16'h0000;
      retaddr_q    <= 16'h0000;
      pending_q    <= 16'h0000;
      irq_en_q     <= 16'h0000;
      irq_prev_q   <= irq_in;
      in_service_q <= 1'b0;
      conflict_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      rd_buf_q     <= rd_buf_d;
      retaddr_q    <= retaddr_d;
      pending_q    <= pending_d;
      irq_en_q     <= irq_en_d;
      irq_prev_q   <= irq_in;
      in_service_q <= in_service_d;
      conflict_q   <= conflict_d;
    end
  end

  assign bus_conflict     = conflict_q;
  assign dbg_state_o      = state_q;
  assign dbg_pending_o    = pending_q;
  assign dbg_in_service_o = in_service_q;

endmodule

// File: tb/tb_io_controller.sv
// Directed bench for io_controller: reads, control-port writes, interrupt priority,
// return from service, masking, d_bus contention and reset during service.
module tb_io_controller;
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RD_HELD = 2'd1;
  localparam logic [1:0] ST_SERVICE = 2'd2;

  logic        clk;
  logic        rst;
  logic [15:0] irq_in;
  logic [3:0]  ext_addr;
  logic        ext_rd, ext_wr;
  logic [15:0] ext_wdata, ext_rdata;
  logic        bus_conflict;
  logic [1:0]  dbg_state;
  logic [15:0] dbg_pending;
  logic        dbg_in_service;
  wire  [15:0] d_bus;
  wire  [15:0] a_bus;
  logic        tb_d_en;
  logic [15:0] tb_d;

  int n_vec;
  int n_err;

  io_controller_if cu_if ();

  assign d_bus     = tb_d_en ? tb_d : 16'hzzzz;
  assign ext_rdata = (ext_addr == 4'd3) ? 16'hBEEF : (16'h1000 | {12'h000, ext_addr});

  io_controller dut (
    .clk              (clk),
    .rst              (rst),
    .cu               (cu_if.slave),
    .d_bus            (d_bus),
    .a_bus            (a_bus),
    .irq_in           (irq_in),
    .ext_addr         (ext_addr),
    .ext_rd           (ext_rd),
    .ext_wr           (ext_wr),
    .ext_wdata        (ext_wdata),
    .ext_rdata        (ext_rdata),
    .bus_conflict     (bus_conflict),
    .dbg_state_o      (dbg_state),
    .dbg_pending_o    (dbg_pending),
    .dbg_in_service_o (dbg_in_service)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; irq_in = 16'h0001;
    cu_if.io_push = 1'b1; tb_d_en = 1'b1; tb_d = 16'h1234;
    tick; tick;
    n_vec++; if (d_bus !== 16'h1234) begin n_err++; $display("FAIL reset_dbus_float got=%h exp=%h", d_bus, 16'h1234); end
    cu_if.io_push = 1'b0; tb_d_en = 1'b0; rst = 1'b0;
    tick;
    n_vec++; if (dbg_pending !== 16'h0000) begin n_err++; $display("FAIL reset_pending got=%h exp=%h", dbg_pending, 16'h0000); end
    n_vec++; if (cu_if.io_interrupt !== 1'b0) begin n_err++; $display("FAIL reset_irq got=%b exp=0", cu_if.io_interrupt); end
    n_vec++; if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, ST_IDLE); end
    n_vec++; if (bus_conflict !== 1'b0) begin n_err++; $display("FAIL reset_conflict got=%b exp=0", bus_conflict); end
    irq_in = 16'h0000;
    tick;
  endtask

  task automatic test_read;
    cu_if.io_read = 1'b1; cu_if.io_addr_read = 1'b1; cu_if.io_addr = 4'd3;
    #1;
    n_vec++; if (ext_rd !== 1'b1) begin n_err++; $display("FAIL read_ext_rd got=%b exp=1", ext_rd); end
    n_vec++; if (ext_addr !== 4'd3) begin n_err++; $display("FAIL read_ext_addr got=%h exp=3", ext_addr); end
    tick;
    cu_if.io_read = 1'b0; cu_if.io_addr_read = 1'b0; cu_if.io_push = 1'b1;
    #1;
    n_vec++; if (ext_rd !== 1'b0) begin n_err++; $display("FAIL read_ext_rd_drop got=%b exp=0", ext_rd); end
    n_vec++; if (dbg_state !== ST_RD_HELD) begin n_err++; $display("FAIL read_state_held got=%0d exp=%0d", dbg_state, ST_RD_HELD); end
    n_vec++; if (d_bus !== 16'hBEEF) begin n_err++; $display("FAIL read_push_data got=%h exp=%h", d_bus, 16'hBEEF); end
    tick;
    cu_if.io_push = 1'b0; tb_d_en = 1'b1; tb_d = 16'h5A5A;
    #1;
    n_vec++; if (d_bus !== 16'h5A5A) begin n_err++; $display("FAIL read_dbus_release got=%h exp=%h", d_bus, 16'h5A5A); end
    n_vec++; if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL read_state_idle got=%0d exp=%0d", dbg_state, ST_IDLE); end
    tb_d_en = 1'b0;
  endtask

  task automatic test_ctrl_write;
    cu_if.io_write = 1'b1; cu_if.io_addr_read = 1'b1; cu_if.io_addr = 4'hF;
    tb_d_en = 1'b1; tb_d = 16'h0024;
    #1;
    n_vec++; if (ext_wr !== 1'b0) begin n_err++; $display("FAIL ctrl_no_ext_wr got=%b exp=0", ext_wr); end
    tick;
    cu_if.io_addr = 4'd6; tb_d = 16'hCAFE;
    #1;
    n_vec++; if (ext_wr !== 1'b1) begin n_err++; $display("FAIL dev_ext_wr got=%b exp=1", ext_wr); end
    n_vec++; if (ext_wdata !== 16'hCAFE) begin n_err++; $display("FAIL dev_wdata got=%h exp=%h", ext_wdata, 16'hCAFE); end
    tick;
    cu_if.io_write = 1'b0; tb_d_en = 1'b0; cu_if.io_read = 1'b1; cu_if.io_addr = 4'hF;
    #1;
    n_vec++; if (ext_rd !== 1'b0) begin n_err++; $display("FAIL ctrl_no_ext_rd got=%b exp=0", ext_rd); end
    tick;
    cu_if.io_read = 1'b0; cu_if.io_addr_read = 1'b0; cu_if.io_push = 1'b1;
    #1;
    n_vec++; if (d_bus !== 16'h0024) begin n_err++; $display("FAIL ctrl_readback got=%h exp=%h", d_bus, 16'h0024); end
    tick;
    cu_if.io_push = 1'b0;
  endtask

  task automatic test_priority;
    irq_in = 16'h0024;
    tick;
    n_vec++; if (dbg_pending !== 16'h0024) begin n_err++; $display("FAIL prio_pending got=%h exp=%h", dbg_pending, 16'h0024); end
    n_vec++; if (cu_if.io_interrupt !== 1'b1) begin n_err++; $display("FAIL prio_irq got=%b exp=1", cu_if.io_interrupt); end
    cu_if.io_push_int_addr = 1'b1;
    #1;
    n_vec++; if (a_bus !== 16'hFFF2) begin n_err++; $display("FAIL prio_vector got=%h exp=%h", a_bus, 16'hFFF2); end
    cu_if.io_push_int_addr = 1'b0;
    cu_if.io_store_retaddr = 1'b1; tb_d_en = 1'b1; tb_d = 16'h0123;
    tick;
    cu_if.io_store_retaddr = 1'b0; tb_d_en = 1'b0;
    #1;
    n_vec++; if (dbg_pending !== 16'h0020) begin n_err++; $display("FAIL ack_pending got=%h exp=%h", dbg_pending, 16'h0020); end
    n_vec++; if (cu_if.io_interrupt !== 1'b0) begin n_err++; $display("FAIL ack_irq got=%b exp=0", cu_if.io_interrupt); end
    n_vec++; if (dbg_in_service !== 1'b1) begin n_err++; $display("FAIL ack_in_service got=%b exp=1", dbg_in_service); end
    n_vec++; if (dbg_state !== ST_SERVICE) begin n_err++; $display("FAIL ack_state got=%0d exp=%0d", dbg_state, ST_SERVICE); end
    cu_if.io_store_retaddr = 1'b1; tb_d_en = 1'b1; tb_d = 16'h0999;
    tick;
    cu_if.io_store_retaddr = 1'b0; tb_d_en = 1'b0;
    #1;
    n_vec++; if (dbg_pending !== 16'h0020) begin n_err++; $display("FAIL service_store_ignored got=%h exp=%h", dbg_pending, 16'h0020); end
  endtask

  task automatic test_return;
    cu_if.io_push_retaddr = 1'b1;
    #1;
    n_vec++; if (d_bus !== 16'h0123) begin n_err++; $display("FAIL ret_data got=%h exp=%h", d_bus, 16'h0123); end
    tick;
    cu_if.io_push_retaddr = 1'b0;
    #1;
    n_vec++; if (dbg_in_service !== 1'b0) begin n_err++; $display("FAIL ret_in_service got=%b exp=0", dbg_in_service); end
    n_vec++; if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL ret_state got=%0d exp=%0d", dbg_state, ST_IDLE); end
    n_vec++; if (cu_if.io_interrupt !== 1'b1) begin n_err++; $display("FAIL ret_irq_again got=%b exp=1", cu_if.io_interrupt); end
    cu_if.io_push_int_addr = 1'b1;
    #1;
    n_vec++; if (a_bus !== 16'hFFF5) begin n_err++; $display("FAIL ret_vector5 got=%h exp=%h", a_bus, 16'hFFF5); end
    cu_if.io_push_int_addr = 1'b0; cu_if.io_push_ints = 1'b1;
    #1;
    n_vec++; if (d_bus !== 16'h0020) begin n_err++; $display("FAIL push_ints got=%h exp=%h", d_bus, 16'h0020); end
    cu_if.io_push_ints = 1'b0;
    cu_if.io_store_retaddr = 1'b1; tb_d_en = 1'b1; tb_d = 16'h0200;
    tick;
    cu_if.io_store_retaddr = 1'b0; tb_d_en = 1'b0; cu_if.io_push_retaddr = 1'b1;
    tick;
    cu_if.io_push_retaddr = 1'b0;
    tick;
    n_vec++; if (dbg_pending !== 16'h0000) begin n_err++; $display("FAIL held_level_no_refire got=%h exp=%h", dbg_pending, 16'h0000); end
    n_vec++; if (cu_if.io_interrupt !== 1'b0) begin n_err++; $display("FAIL held_level_irq got=%b exp=0", cu_if.io_interrupt); end
    irq_in = 16'h0000;
    tick;
  endtask

  task automatic test_masking;
    irq_in = 16'h0080;
    tick;
    n_vec++; if (dbg_pending !== 16'h0080) begin n_err++; $display("FAIL mask_pending got=%h exp=%h", dbg_pending, 16'h0080); end
    n_vec++; if (cu_if.io_interrupt !== 1'b0) begin n_err++; $display("FAIL mask_irq got=%b exp=0", cu_if.io_interrupt); end
    cu_if.io_push_int_addr = 1'b1;
    #1;
    n_vec++; if (a_bus !== 16'hFFF0) begin n_err++; $display("FAIL mask_vector_base got=%h exp=%h", a_bus, 16'hFFF0); end
    cu_if.io_push_int_addr = 1'b0;
    cu_if.io_write = 1'b1; cu_if.io_addr_read = 1'b1; cu_if.io_addr = 4'hF;
    tb_d_en = 1'b1; tb_d = 16'h00A4;
    tick;
    cu_if.io_write = 1'b0; cu_if.io_addr_read = 1'b0; tb_d_en = 1'b0;
    #1;
    n_vec++; if (cu_if.io_interrupt !== 1'b1) begin n_err++; $display("FAIL unmask_irq got=%b exp=1", cu_if.io_interrupt); end
    irq_in = 16'h0000;
    tick;
    irq_in = 16'h0080; cu_if.io_store_retaddr = 1'b1; tb_d_en = 1'b1; tb_d = 16'h0300;
    tick;
    cu_if.io_store_retaddr = 1'b0; tb_d_en = 1'b0;
    #1;
    n_vec++; if (dbg_pending !== 16'h0080) begin n_err++; $display("FAIL set_beats_clear got=%h exp=%h", dbg_pending, 16'h0080); end
    n_vec++; if (dbg_state !== ST_SERVICE) begin n_err++; $display("FAIL set_clear_state got=%0d exp=%0d", dbg_state, ST_SERVICE); end
    cu_if.io_push_retaddr = 1'b1;
    tick;
    cu_if.io_push_retaddr = 1'b0;
    #1;
    n_vec++; if (cu_if.io_interrupt !== 1'b1) begin n_err++; $display("FAIL resurrected_irq got=%b exp=1", cu_if.io_interrupt); end
    cu_if.io_store_retaddr = 1'b1; tb_d_en = 1'b1; tb_d = 16'h0301;
    tick;
    cu_if.io_store_retaddr = 1'b0; tb_d_en = 1'b0; cu_if.io_push_retaddr = 1'b1;
    tick;
    cu_if.io_push_retaddr = 1'b0;
    tick;
    n_vec++; if (dbg_pending !== 16'h0000) begin n_err++; $display("FAIL mask_held_clear got=%h exp=%h", dbg_pending, 16'h0000); end
  endtask

  task automatic test_conflict;
    cu_if.io_push = 1'b1; cu_if.io_push_ints = 1'b1;
    #1;
    n_vec++; if (d_bus !== 16'h0024) begin n_err++; $display("FAIL conflict_winner got=%h exp=%h", d_bus, 16'h0024); end
    n_vec++; if (bus_conflict !== 1'b0) begin n_err++; $display("FAIL conflict_not_yet got=%b exp=0", bus_conflict); end
    tick;
    cu_if.io_push = 1'b0; cu_if.io_push_ints = 1'b0;
    #1;
    n_vec++; if (bus_conflict !== 1'b1) begin n_err++; $display("FAIL conflict_pulse got=%b exp=1", bus_conflict); end
    tick;
    n_vec++; if (bus_conflict !== 1'b0) begin n_err++; $display("FAIL conflict_one_cycle got=%b exp=0", bus_conflict); end
  endtask

  task automatic test_reset_service;
    irq_in = 16'h0004;
    tick;
    n_vec++; if (cu_if.io_interrupt !== 1'b1) begin n_err++; $display("FAIL rs_irq got=%b exp=1", cu_if.io_interrupt); end
    cu_if.io_store_retaddr = 1'b1; tb_d_en = 1'b1; tb_d = 16'h0777;
    tick;
    cu_if.io_store_retaddr = 1'b0; tb_d_en = 1'b0; irq_in = 16'h0024;
    tick;
    n_vec++; if (dbg_pending !== 16'h0020) begin n_err++; $display("FAIL rs_pending got=%h exp=%h", dbg_pending, 16'h0020); end
    n_vec++; if (dbg_state !== ST_SERVICE) begin n_err++; $display("FAIL rs_state got=%0d exp=%0d", dbg_state, ST_SERVICE); end
    rst = 1'b1; cu_if.io_push_retaddr = 1'b1; tb_d_en = 1'b1; tb_d = 16'h5A5A;
    #1;
    n_vec++; if (d_bus !== 16'h5A5A) begin n_err++; $display("FAIL rs_dbus_float got=%h exp=%h", d_bus, 16'h5A5A); end
    tick;
    rst = 1'b0; cu_if.io_push_retaddr = 1'b0; tb_d_en = 1'b0;
    #1;
    n_vec++; if (cu_if.io_interrupt !== 1'b0) begin n_err++; $display("FAIL rs_irq_clear got=%b exp=0", cu_if.io_interrupt); end
    n_vec++; if (dbg_pending !== 16'h0000) begin n_err++; $display("FAIL rs_pending_clear got=%h exp=%h", dbg_pending, 16'h0000); end
    n_vec++; if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL rs_state_idle got=%0d exp=%0d", dbg_state, ST_IDLE); end
    n_vec++; if (dbg_in_service !== 1'b0) begin n_err++; $display("FAIL rs_in_service got=%b exp=0", dbg_in_service); end
    tick;
    n_vec++; if (dbg_pending !== 16'h0000) begin n_err++; $display("FAIL rs_held_no_fire got=%h exp=%h", dbg_pending, 16'h0000); end
    cu_if.io_push_retaddr = 1'b1;
    #1;
    n_vec++; if (d_bus !== 16'h0000) begin n_err++; $display("FAIL rs_retaddr_discarded got=%h exp=%h", d_bus, 16'h0000); end
    cu_if.io_push_retaddr = 1'b0;
    tick;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    irq_in = 16'h0000;
    tb_d_en = 1'b0;
    tb_d = 16'h0000;
    cu_if.io_read = 1'b0;
    cu_if.io_write = 1'b0;
    cu_if.io_push = 1'b0;
    cu_if.io_addr_read = 1'b0;
    cu_if.io_addr = 4'h0;
    cu_if.io_store_retaddr = 1'b0;
    cu_if.io_push_retaddr = 1'b0;
    cu_if.io_push_ints = 1'b0;
    cu_if.io_push_int_addr = 1'b0;

    test_reset;
    test_read;
    test_ctrl_write;
    test_priority;
    test_return;
    test_masking;
    test_conflict;
    test_reset_service;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
